// File: rtl/checkbit_streamer.sv
// Publishes 32-bit results on the 16-bit checkbits field as START_MARK, hi/lo halves per word,
// then END_MARK, holding every value for HOLD_CYCLES so a slow level-sampling monitor can see it.
//
// state | meaning
// IDLE  | waiting for start; shows IDLE_VAL after reset, END_MARK after a transfer
// SMARK | showing START_MARK
// WAIT  | words still owed but FIFO empty; previous value stays on checkbits
// HI    | showing upper half of the current word
// LO    | showing lower half of the current word
// EMARK | showing END_MARK; done pulses as the hold expires
module checkbit_streamer #(
    parameter int          HOLD_CYCLES = 64,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] START_MARK  = 16'hAB30,
    parameter logic [15:0] END_MARK    = 16'hAB31,
    parameter logic [15:0] IDLE_VAL    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  len,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic [15:0] checkbits,
    output logic        busy,
    output logic        done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_SMARK, S_WAIT, S_HI, S_LO, S_EMARK} state_t;

    state_t        state;
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   fifo_head;
    logic          fifo_empty, push, pop, hold_zero;
    logic [HW-1:0] hold;
    logic [7:0]    remaining;
    logic [15:0]   word_lo;

    // s_ready depends only on the occupancy register, never on s_valid
    assign s_ready    = (count != FULL_CNT);
    assign fifo_empty = (count == '0);
    assign push       = s_valid && s_ready;
    assign fifo_head  = fifo_mem[rd_ptr];
    assign hold_zero  = (hold == '0);

    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            case (state)
                S_WAIT:        pop = 1'b1;
                S_SMARK, S_LO: pop = hold_zero && (remaining != 8'd0);
                default:       pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            checkbits <= IDLE_VAL;
            busy      <= 1'b0;
            done      <= 1'b0;
            hold      <= '0;
            remaining <= '0;
            word_lo   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_SMARK;
                        checkbits <= START_MARK;
                        busy      <= 1'b1;
                        remaining <= len;
                        hold      <= HOLD_LOAD;
                    end
                end
                S_SMARK, S_LO: begin
                    if (!hold_zero) begin
                        hold <= hold - 1'b1;
                    end else if (remaining == 8'd0) begin
                        state     <= S_EMARK;
                        checkbits <= END_MARK;
                        hold      <= HOLD_LOAD;
                    end else if (pop) begin
                        state     <= S_HI;
                        checkbits <= fifo_head[31:16];
                        word_lo   <= fifo_head[15:0];
                        hold      <= HOLD_LOAD;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (pop) begin
                        state     <= S_HI;
                        checkbits <= fifo_head[31:16];
                        word_lo   <= fifo_head[15:0];
                        hold      <= HOLD_LOAD;
                    end
                end
                S_HI: begin
                    if (!hold_zero) begin
                        hold <= hold - 1'b1;
                    end else begin
                        state     <= S_LO;
                        checkbits <= word_lo;
                        remaining <= remaining - 1'b1;
                        hold      <= HOLD_LOAD;
                    end
                end
                S_EMARK: begin
                    // END_MARK stays on checkbits through IDLE until the next start
                    if (!hold_zero) begin
                        hold <= hold - 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
